// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   PORT_CPU / PORT_IO : port index of each requester
//   tag_t              : per-access tag carried alongside the memory access
//   RD_LAT             : cycles from grant to rvalid
package mem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;
  localparam int   RD_LAT   = 2;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_write;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, port: 1'b0, is_write: 1'b0};

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin selection.
//   i_req  : request vector, bit N = port N
//   i_last : port granted most recently
//   o_gnt  : one-hot grant (all zero when nobody requests)
//   o_last : pointer value to register for the next cycle
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  always_comb begin
    o_gnt  = 2'b00;
    o_last = i_last;
    case (i_req)
      2'b01: begin
        o_gnt  = 2'b01;
        o_last = PORT_CPU;
      end
      2'b10: begin
        o_gnt  = 2'b10;
        o_last = PORT_IO;
      end
      2'b11: begin
        // tie: favour the port that did not win last time
        if (i_last == PORT_IO) begin
          o_gnt  = 2'b01;
          o_last = PORT_CPU;
        end else begin
          o_gnt  = 2'b10;
          o_last = PORT_IO;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between the
// CPU (port 0) and an I/O / debug master (port 1).
//   clk, rst_n                 : clock, async active-low reset
//   reqN/weN/addrN/wdataN      : request side of port N
//   gntN                       : combinational grant for port N
//   rvalidN/rdataN             : read return for port N, RD_LAT after grant
//   mem_we/mem_addr/mem_data   : registered memory command
//   mem_out                    : registered read data from the memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  logic                  r_last;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  tag_t                  r_tag [RD_LAT];

  logic [1:0]            w_gnt;
  logic                  w_last_nxt;
  logic                  w_any;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  tag_t                  w_tag_in;
  tag_t                  w_tag_out;

  rr_picker u_picker (
    .i_req  ({req1, req0}),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_last (w_last_nxt)
  );

  assign w_any      = |w_gnt;
  assign w_sel_we   = w_gnt[1] ? we1    : we0;
  assign w_sel_addr = w_gnt[1] ? addr1  : addr0;
  assign w_sel_data = w_gnt[1] ? wdata1 : wdata0;
  assign w_tag_in   = '{valid: w_any, port: w_gnt[1], is_write: w_sel_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= PORT_IO;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= TAG_NONE;
    end else begin
      r_last   <= w_last_nxt;
      // idle cycles issue a read of the held address, which is harmless
      r_mem_we <= w_any & w_sel_we;
      if (w_any) begin
        r_mem_addr <= w_sel_addr;
        r_mem_data <= w_sel_data;
      end
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out = r_tag[RD_LAT-1];

  assign gnt0     = w_gnt[0];
  assign gnt1     = w_gnt[1];
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign rvalid0  = w_tag_out.valid & ~w_tag_out.is_write & (w_tag_out.port == PORT_CPU);
  assign rvalid1  = w_tag_out.valid & ~w_tag_out.is_write & (w_tag_out.port == PORT_IO);
  assign rdata0   = mem_out;
  assign rdata1   = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_data, mem_out;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  // memory fixture: synchronous, write-through, no reset
  logic [DW-1:0] fx_mem [64];
  logic [DW-1:0] fx_q;
  always @(posedge clk) begin
    if (mem_we) fx_mem[mem_addr] <= mem_data;
    fx_q <= mem_we ? mem_data : fx_mem[mem_addr];
  end
  assign mem_out = fx_q;

  // reference model: word array updated at grant time, round-robin pointer
  logic [DW-1:0] ref_mem [64];
  bit            ref_last;
  bit            ref_mem_we;
  int            cyc = 0;
  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t q0[$], q1[$];

  bit            pend [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // monitor: compares read returns against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev0, ev1;
      ev0 = (q0.size() > 0) && (q0[0].due == cyc);
      ev1 = (q1.size() > 0) && (q1[0].due == cyc);
      check("rvalid0", rvalid0, ev0);
      check("rvalid1", rvalid1, ev1);
      if (ev0) begin
        if (rvalid0) check("rdata0", rdata0, q0[0].data);
        void'(q0.pop_front());
      end
      if (ev1) begin
        if (rvalid1) check("rdata1", rdata1, q1[0].data);
        void'(q1.pop_front());
      end
    end
  end

  task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; p_we[p] = w; p_addr[p] = a; p_data[p] = d;
  endtask

  // one cycle; entered and left at posedge+1
  task automatic step();
    int win;
    req0 = pend[0]; we0 = pend[0] ? p_we[0] : 1'($urandom);
    addr0 = pend[0] ? p_addr[0] : AW'($urandom); wdata0 = pend[0] ? p_data[0] : DW'($urandom);
    req1 = pend[1]; we1 = pend[1] ? p_we[1] : 1'($urandom);
    addr1 = pend[1] ? p_addr[1] : AW'($urandom); wdata1 = pend[1] ? p_data[1] : DW'($urandom);
    @(negedge clk);
    if (pend[0] && pend[1]) win = ref_last ? 0 : 1;
    else if (pend[0]) win = 0;
    else if (pend[1]) win = 1;
    else win = -1;
    check("gnt0", gnt0, win == 0);
    check("gnt1", gnt1, win == 1);
    check("mem_we", mem_we, ref_mem_we);
    if (win >= 0) begin
      ref_last   = (win == 1);
      ref_mem_we = p_we[win];
      if (p_we[win]) ref_mem[p_addr[win]] = p_data[win];
      else if (win == 0) q0.push_back('{ref_mem[p_addr[0]], cyc + 2});
      else q1.push_back('{ref_mem[p_addr[1]], cyc + 2});
      pend[win] = 1'b0;
    end else begin
      ref_mem_we = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    ref_last = 1'b1; ref_mem_we = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      fx_mem[i] = v; ref_mem[i] = v;
    end
    fx_mem[8] = 16'h7101; ref_mem[8] = 16'h7101;
    fx_mem[9] = 16'h8101; ref_mem[9] = 16'h8101;
    ref_last = 1'b1; ref_mem_we = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;

    @(negedge clk);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_data", mem_data, 0);
    check("reset_rvalid0", rvalid0, 1'b0);
    check("reset_rvalid1", rvalid1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // write then read back on port 0
    set_req(0, 1'b1, 6'd5, 16'h1234); step();
    set_req(0, 1'b0, 6'd5, 16'h0000); step();
    idle(3);

    // simultaneous reads from a fresh pointer
    rst_pulse();
    set_req(0, 1'b0, 6'd8, 16'h0); set_req(1, 1'b0, 6'd9, 16'h0);
    step(); step();
    idle(3);

    // both held for 6 cycles with mixed read/write
    for (int i = 0; i < 6; i++) begin
      if (!pend[0]) set_req(0, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      if (!pend[1]) set_req(1, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      step();
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    idle(3);

    // back-to-back write then read of the same word across ports
    set_req(1, 1'b1, 6'd20, 16'hF000); step();
    set_req(0, 1'b0, 6'd20, 16'h0000); step();
    idle(3);

    // reset while a read is in flight
    set_req(0, 1'b0, 6'd8, 16'h0); step();
    rst_pulse();
    idle(3);
    set_req(0, 1'b0, 6'd8, 16'h0); step();
    idle(3);

    // idle after a write, then read it back
    set_req(0, 1'b1, 6'd30, DW'($urandom)); step();
    idle(4);
    set_req(1, 1'b0, 6'd30, 16'h0); step();
    idle(3);

    // randomized traffic; requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (!pend[0] && $urandom_range(0, 2) != 0)
        set_req(0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      if (!pend[1] && $urandom_range(0, 2) != 0)
        set_req(1, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
      step();
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    idle(4);

    check("queues_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
